// File: rtl/eth_fc_rx_sideband_gen_if.sv
// Sideband RX message handshake bundle (AXI-S style valid/ready).
// Master drives tvalid/tdata, slave drives tready.
interface eth_fc_rx_sideband_gen_if #(
    parameter int W = 9
);
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/eth_fc_rx_sideband_gen.sv
// RX flow-control sideband reporter: turns pause/PFC XOFF levels
// into sideband messages on change, with periodic refresh and coalescing.
module eth_fc_rx_sideband_gen #(
    parameter int NUM_PFC        = 8,
    parameter int REFRESH_CYCLES = 4096,
    parameter int MIN_GAP        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enable,
    input  logic                   i_rx_pause,
    input  logic [NUM_PFC-1:0]     i_rx_pfc,
    eth_fc_rx_sideband_gen_if.master sb,
    output logic [31:0]            o_msg_cnt,
    output logic [15:0]            o_coalesce_cnt
);
    localparam int W  = NUM_PFC + 1;
    localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam bit REFRESH_EN = (REFRESH_CYCLES != 0);
    localparam logic [TW-1:0] T_LAST =
        TW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam logic [GW-1:0] G_LAST =
        GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   cur_q;
    logic [W-1:0]   last_sent;
    logic [W-1:0]   tdata_q;
    logic           tvalid_q;
    logic [TW-1:0]  timer;
    logic [GW-1:0]  gap_cnt;
    logic [31:0]    msg_cnt;
    logic [15:0]    coal_cnt;
    logic [W-1:0]   in_vec;
    logic           changed;
    logic           refresh_due;

    assign in_vec      = {i_rx_pfc, i_rx_pause};
    assign changed     = (cur_q != last_sent);
    assign refresh_due = REFRESH_EN && (|cur_q) && (timer == T_LAST);

    assign sb.tvalid      = tvalid_q;
    assign sb.tdata       = tdata_q;
    assign o_msg_cnt      = msg_cnt;
    assign o_coalesce_cnt = coal_cnt;

    // Input sampling, message FSM, refresh timer and statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_q     <= '0;
            last_sent <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            timer     <= '0;
            gap_cnt   <= '0;
            msg_cnt   <= '0;
            coal_cnt  <= '0;
        end else begin
            cur_q <= in_vec;
            unique case (state)
                IDLE: begin
                    if (i_enable && (changed || refresh_due)) begin
                        state    <= SEND;
                        tvalid_q <= 1'b1;
                        tdata_q  <= cur_q;
                        timer    <= '0;
                    end else if (cur_q == '0) begin
                        timer <= '0;
                    end else if (i_enable) begin
                        timer <= timer + TW'(1);
                    end
                end
                SEND: begin
                    if (sb.tready) begin
                        last_sent <= tdata_q;
                        msg_cnt   <= msg_cnt + 32'd1;
                        tvalid_q  <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= (MIN_GAP > 0) ? GAP : IDLE;
                    end else if (in_vec != cur_q && coal_cnt != 16'hFFFF) begin
                        // tdata stays frozen; newest cur_q goes out from IDLE
                        coal_cnt <= coal_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == G_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_eth_fc_rx_sideband_gen.sv
// Randomized + directed bench for eth_fc_rx_sideband_gen with a
// transaction scoreboard fed by a behavioural reference model.
module tb_eth_fc_rx_sideband_gen;
    localparam int NP = 8;
    localparam int RC = 16;
    localparam int MG = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          pause = 1'b0;
    logic [NP-1:0] pfc = '0;
    logic [31:0]   msg_cnt;
    logic [15:0]   coal_cnt;

    eth_fc_rx_sideband_gen_if #(.W(NP + 1)) sb ();

    eth_fc_rx_sideband_gen #(
        .NUM_PFC(NP),
        .REFRESH_CYCLES(RC),
        .MIN_GAP(MG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_enable(en),
        .i_rx_pause(pause),
        .i_rx_pfc(pfc),
        .sb(sb),
        .o_msg_cnt(msg_cnt),
        .o_coalesce_cnt(coal_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          at;
        logic [NP:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state (behavioural, integer based)
    logic [NP:0] m_cur = '0;
    logic [NP:0] m_sent = '0;
    logic [NP:0] m_data = '0;
    bit          m_busy = 0;
    int          m_gap = 0;
    int          m_quiet = 0;
    logic [31:0] m_msgs = '0;
    int          m_coal = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                         name, act, exp, cyc);
        end
    endtask

    // One clock of spec-level behaviour; inputs are those seen at the edge.
    task automatic step();
        logic [NP:0] nxt;
        bit          fire;
        nxt = {pfc, pause};
        if (!rst_n) begin
            m_cur = '0; m_sent = '0; m_data = '0; m_busy = 0;
            m_gap = 0; m_quiet = 0; m_msgs = '0; m_coal = 0;
        end else begin
            if (m_busy) begin
                if (sb.tready) begin
                    m_sent = m_data;
                    m_msgs = m_msgs + 1;
                    m_busy = 0;
                    m_gap  = MG;
                end else if (nxt != m_cur && m_coal < 65535) begin
                    m_coal++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                fire = 0;
                if (en && m_cur != m_sent) fire = 1;
                else if (en && RC != 0 && m_cur != 0 && m_quiet == RC - 1)
                    fire = 1;
                if (fire) begin
                    m_busy  = 1;
                    m_data  = m_cur;
                    m_quiet = 0;
                    exp_q.push_back('{at: cyc + 1, data: m_cur});
                end else if (m_cur != 0 && en) begin
                    m_quiet++;
                end
            end
            if (m_cur == 0) m_quiet = 0;
            m_cur = nxt;
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        step();
    end

    // Monitor: pops expectations when a new message appears; checks state.
    initial begin
        bit   prev_v;
        bit   prev_acc;
        exp_t e;
        prev_v = 0;
        prev_acc = 0;
        forever begin
            @(negedge clk);
            if (sb.tvalid === 1'b1 && (!prev_v || prev_acc)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_msg", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("msg_cycle", 32'(cyc), 32'(e.at));
                    chk("msg_data", 32'(sb.tdata), 32'(e.data));
                end
            end
            chk("tvalid", 32'(sb.tvalid), 32'(m_busy));
            if (m_busy) chk("tdata_hold", 32'(sb.tdata), 32'(m_data));
            chk("msg_cnt", msg_cnt, m_msgs);
            chk("coalesce_cnt", 32'(coal_cnt), 32'(m_coal));
            prev_v   = (sb.tvalid === 1'b1);
            prev_acc = (sb.tvalid === 1'b1) && (sb.tready === 1'b1);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        int idx;
        sb.tready = 1'b0;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        en = 1'b1;
        sb.tready = 1'b1;
        while (cyc < 10) tick();
        // Pause on then off
        pause = 1'b1;
        tick(12);
        pause = 1'b0;
        tick(12);
        // Stall and coalesce PFC changes
        sb.tready = 1'b0;
        pfc = 8'h01;
        tick(4);
        pfc = 8'h03;
        tick(2);
        pfc = 8'h07;
        tick(3);
        sb.tready = 1'b1;
        tick(12);
        pfc = 8'h00;
        tick(12);
        // Steady XOFF refresh, then release
        pfc = 8'h80;
        tick(80);
        pfc = 8'h00;
        tick(40);
        // Disabled: toggles produce nothing until re-enable
        en = 1'b0;
        pause = 1'b1;
        tick(3);
        pause = 1'b0;
        tick(3);
        pause = 1'b1;
        tick(6);
        en = 1'b1;
        tick(10);
        pause = 1'b0;
        tick(10);
        // Reset while stalled with tvalid high
        sb.tready = 1'b0;
        pause = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(5);
        sb.tready = 1'b1;
        tick(8);
        pause = 1'b0;
        tick(10);
        // Short PFC pulse during GAP is invisible
        pfc = 8'h10;
        n = 0;
        while (sb.tvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("wait_tvalid", 32'd0, 32'd1);
        tick();
        tick();
        pfc = 8'h18;
        tick();
        pfc = 8'h10;
        tick(12);
        pfc = 8'h00;
        tick(10);
        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            sb.tready = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 19) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 9) == 0) pause = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                idx = $urandom_range(0, NP - 1);
                pfc[idx] = ~pfc[idx];
            end
            tick();
        end
        rst_n = 1'b1;
        en = 1'b1;
        sb.tready = 1'b1;
        pause = 1'b0;
        pfc = '0;
        tick(40);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
